aes128_key_expander: RTL and testbench

//  Iterative AES-128 key schedule for the encrypt datapath (FIPS-197 sec. 5.2).

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes128_key_expander.sv | 114 +++++++++++
 tb/tb_aes128_key_expander.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key schedule.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  localparam int AES128_NR = 10;

  // Round constants for rounds 1..10 of the AES-128 schedule.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: one byte in, one byte out, purely combinational.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Table packed MSB-first: entry 0 occupies bits [2047:2040].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base = 11'd2047 - {a_i, 3'b000};
  assign s_o  = SBOX_TBL[base -: 8];

endmodule

// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key schedule: loads a cipher key and streams round
// keys 0..10 over a valid/ready interface, one new key per handshake.
module aes128_key_expander
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic             abort_i,
  output logic [KEY_W-1:0] rk_o,
  output logic [3:0]       rk_idx_o,
  output logic             rk_last_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i
);

  if (NR != AES128_NR || KEY_W != 128) begin : g_param_chk
    $error("aes128_key_expander supports only NR=10 and KEY_W=128");
  end

  state_e     state_q, state_d;
  block_t     rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;

  word_t  w0, w1, w2, w3;
  word_t  rot_w, sub_w, t_w;
  word_t  n0, n1, n2, n3;
  block_t key_next;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  // SubWord: one S-box per byte of the rotated last word.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i(rot_w[8*i +: 8]),
      .s_o(sub_w[8*i +: 8])
    );
  end

  // Next round key from the current one; a single S-box level per cycle.
  always_comb begin
    t_w      = sub_w ^ {rcon_q, 24'h000000};
    n0       = w0 ^ t_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    key_next = {n0, n1, n2, n3};
  end

  // Next-state and handshake outputs; abort overrides every handshake.
  always_comb begin
    state_d     = state_q;
    rk_d        = rk_q;
    idx_d       = idx_q;
    rcon_d      = rcon_q;
    key_ready_o = (state_q == ST_IDLE);
    rk_valid_o  = (state_q == ST_RUN);
    if (abort_i) begin
      state_d = ST_IDLE;
      idx_d   = 4'd0;
      rcon_d  = 8'h01;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_valid_i) begin
            rk_d    = key_i;
            idx_d   = 4'd0;
            rcon_d  = 8'h01;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (rk_ready_i) begin
            if (idx_q == 4'(NR)) begin
              state_d = ST_IDLE;
            end else begin
              rk_d   = key_next;
              idx_d  = idx_q + 4'd1;
              rcon_d = xtime(rcon_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, round key, index and round constant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign rk_o      = rk_q;
  assign rk_idx_o  = idx_q;
  assign rk_last_o = (idx_q == 4'(NR));

endmodule

// File: tb/tb_aes128_key_expander.sv
// Directed bench for the AES-128 key expander using FIPS-197 vectors.
module tb_aes128_key_expander;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_i;
  logic         key_valid_i;
  logic         key_ready_o;
  logic         abort_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_last_o;
  logic         rk_valid_o;
  logic         rk_ready_i;

  int nvec  = 0;
  int nfail = 0;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z  = 128'h0;

  // FIPS-197 appendix A.1 round keys 0..10.
  logic [127:0] a1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes128_key_expander #(.NR(10), .KEY_W(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_i      (key_i),
    .key_valid_i(key_valid_i),
    .key_ready_o(key_ready_o),
    .abort_i    (abort_i),
    .rk_o       (rk_o),
    .rk_idx_o   (rk_idx_o),
    .rk_last_o  (rk_last_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key for one accepting edge; DUT must be idle.
  task automatic load_key(input logic [127:0] k);
    key_i       = k;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
  endtask

  // Stream all eleven A.1 round keys under constant ready.
  task automatic run_a1(input string tag);
    rk_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      chk({tag, "_valid"}, 128'(rk_valid_o), 128'd1);
      chk({tag, "_idx"},   128'(rk_idx_o), 128'(i));
      chk({tag, "_rk"},    rk_o, a1[i]);
      chk({tag, "_last"},  128'(rk_last_o), 128'(i == 10));
      tick();
    end
    chk({tag, "_end_valid"}, 128'(rk_valid_o), 128'd0);
    chk({tag, "_end_ready"}, 128'(key_ready_o), 128'd1);
  endtask

  initial begin
    int exp_i;
    int budget;
    rst_n       = 1'b0;
    key_i       = '0;
    key_valid_i = 1'b0;
    abort_i     = 1'b0;
    rk_ready_i  = 1'b0;

    // Reset values
    #2;
    chk("rst_rk",    rk_o, 128'd0);
    chk("rst_idx",   128'(rk_idx_o), 128'd0);
    chk("rst_valid", 128'(rk_valid_o), 128'd0);
    chk("rst_kready", 128'(key_ready_o), 128'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: FIPS-197 A.1 with constant ready
    load_key(KEY_A1);
    run_a1("a1");

    // 2: all-zero key
    load_key(KEY_Z);
    rk_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      chk("zero_idx", 128'(rk_idx_o), 128'(i));
      if (i == 1)  chk("zero_rk1",  rk_o, 128'h62636363626363636263636362636363);
      if (i == 10) chk("zero_rk10", rk_o, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      tick();
    end
    chk("zero_end_valid", 128'(rk_valid_o), 128'd0);

    // 3: random backpressure on A.1
    load_key(KEY_A1);
    exp_i  = 0;
    budget = 0;
    while (exp_i < 11 && budget < 400) begin
      chk("bp_valid", 128'(rk_valid_o), 128'd1);
      chk("bp_idx",   128'(rk_idx_o), 128'(exp_i));
      chk("bp_rk",    rk_o, a1[exp_i]);
      rk_ready_i = 1'($urandom_range(0, 1));
      if (rk_ready_i) exp_i++;
      tick();
      budget++;
    end
    chk("bp_done", 128'(exp_i), 128'd11);
    chk("bp_end_valid", 128'(rk_valid_o), 128'd0);

    // 4: key_valid held during RUN is ignored; next key accepted right after
    key_i       = KEY_A1;
    key_valid_i = 1'b1;
    rk_ready_i  = 1'b1;
    tick();
    key_i = KEY_Z;
    for (int i = 0; i < 11; i++) begin
      chk("hold_kready", 128'(key_ready_o), 128'd0);
      chk("hold_rk",     rk_o, a1[i]);
      tick();
    end
    chk("hold_idle_valid",  128'(rk_valid_o), 128'd0);
    chk("hold_idle_kready", 128'(key_ready_o), 128'd1);
    tick();
    key_valid_i = 1'b0;
    chk("hold_new_idx", 128'(rk_idx_o), 128'd0);
    chk("hold_new_rk",  rk_o, KEY_Z);
    tick();
    chk("hold_new_rk1", rk_o, 128'h62636363626363636263636362636363);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // 5: abort at idx5 with simultaneous ready
    load_key(KEY_A1);
    rk_ready_i = 1'b1;
    budget = 0;
    while (rk_idx_o != 4'd5 && budget < 20) begin
      tick();
      budget++;
    end
    chk("abort_reach5", 128'(rk_idx_o), 128'd5);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_valid",  128'(rk_valid_o), 128'd0);
    chk("abort_kready", 128'(key_ready_o), 128'd1);
    chk("abort_idx",    128'(rk_idx_o), 128'd0);
    chk("abort_rk",     rk_o, a1[5]);
    // abort beats a key handshake in IDLE
    key_i       = KEY_Z;
    key_valid_i = 1'b1;
    abort_i     = 1'b1;
    tick();
    key_valid_i = 1'b0;
    abort_i     = 1'b0;
    chk("abort_prio_valid", 128'(rk_valid_o), 128'd0);
    chk("abort_prio_rk",    rk_o, a1[5]);
    load_key(KEY_A1);
    run_a1("abort_reload");

    // 6: asynchronous reset mid-stream
    load_key(KEY_A1);
    rk_ready_i = 1'b1;
    tick();
    tick();
    tick();
    chk("arst_pre_idx", 128'(rk_idx_o), 128'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rk",     rk_o, 128'd0);
    chk("arst_idx",    128'(rk_idx_o), 128'd0);
    chk("arst_valid",  128'(rk_valid_o), 128'd0);
    chk("arst_kready", 128'(key_ready_o), 128'd1);
    tick();
    rst_n = 1'b1;
    tick();
    load_key(KEY_A1);
    run_a1("arst_reload");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
